// File: rtl/mem_burst_ctrl.sv
// Burst command sequencer in front of a single-port memory: splits one burst into single-beat requests.
// Optional RESP watchdog enabled by defining MEM_BURST_TIMEOUT_EN.
module mem_burst_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [WIDTH-1:0]      wd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_last,
    output logic                  mem_valid,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

    state_t                state, state_nx;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_inc;
    logic [LEN_WIDTH-1:0]  len_q, beat_q;
    logic                  last_beat;
    logic                  req_go;
    logic                  timeout_hit;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_burst_ctrl: TIMEOUT must be at least 1");
    end

    assign last_beat = (beat_q == len_q);
    assign addr_inc  = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
    assign req_go    = !wr_q || wd_valid;
    assign cmd_ready = (state == IDLE);
    assign wd_ready  = (state == REQ) && wr_q;
    assign busy      = (state != IDLE);

`ifdef MEM_BURST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    // Counts completed RESP cycles; fires on the last allowed one.
    always_ff @(posedge clk or negedge res) begin
        if (!res)
            tcnt <= '0;
        else if (state != RESP)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    assign timeout_hit = (state == RESP) && !mem_ready && (tcnt == TW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cmd_valid) state_nx = REQ;
            REQ:  if (req_go) state_nx = RESP;
            RESP: begin
                if (mem_ready) begin
                    if (!wr_q)
                        state_nx = OUT;
                    else
                        state_nx = last_beat ? IDLE : REQ;
                end else if (timeout_hit) begin
                    state_nx = IDLE;
                end
            end
            OUT:  if (rd_ready) state_nx = last_beat ? IDLE : REQ;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            mem_valid <= 1'b0;
            mem_wr_rd <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wr_q   <= cmd_wr;
                        addr_q <= cmd_addr;
                        len_q  <= cmd_len;
                        beat_q <= '0;
                        err    <= 1'b0;
                    end
                end
                REQ: begin
                    if (req_go) begin
                        mem_valid <= 1'b1;
                        mem_wr_rd <= wr_q;
                        mem_addr  <= addr_q;
                        if (wr_q) mem_wdata <= wd_data;
                    end
                end
                RESP: begin
                    if (mem_ready) begin
                        if (!wr_q) begin
                            rd_data  <= mem_rdata;
                            rd_valid <= 1'b1;
                            rd_last  <= last_beat;
                        end else if (!last_beat) begin
                            addr_q <= addr_inc;
                            beat_q <= beat_q + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        err <= 1'b1;
                    end
                end
                OUT: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        if (!last_beat) begin
                            addr_q <= addr_inc;
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed self-checking bench for mem_burst_ctrl with a one-cycle-latency memory model.
// Timeout checks run only when MEM_BURST_TIMEOUT_EN is defined.
module tb_mem_burst_ctrl;

    logic       clk = 1'b0;
    logic       res;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [7:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wd_valid, wd_ready;
    logic [7:0] wd_data;
    logic       rd_valid, rd_ready, rd_last;
    logic [7:0] rd_data;
    logic       mem_valid, mem_wr_rd;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ready = 1'b0;
    logic       busy, err;
    logic       mem_block = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic [7:0] model [256];
    logic [7:0] wbuf [17];
    logic [7:0] rbuf [17];
    logic       rlast [17];
    logic [7:0] abuf [40];
    int         nr, na;

    always #5 clk = ~clk;

    mem_burst_ctrl #(.WIDTH(8), .DEPTH(256), .ADDR_WIDTH(8), .LEN_WIDTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .res(res),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .mem_valid(mem_valid), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .err(err)
    );

    // Memory: request sampled on an edge, ready/rdata presented for the following cycle.
    always @(posedge clk) begin
        mem_ready <= mem_valid && !mem_block;
        if (mem_valid) begin
            if (mem_wr_rd) mem[mem_addr] <= mem_wdata;
            else           mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [7:0] a, input logic [3:0] l);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_write(input logic [7:0] a, input logic [3:0] l, input int sb, input int sc,
                             output int cyc);
        int   idx = 0;
        int   st  = 0;
        logic fire;
        na = 0;
        wd_valid = 1'b1;
        wd_data  = wbuf[0];
        issue(1'b1, a, l);
        cyc = 0;
        while (busy && cyc < 300) begin
            if (mem_valid && na < 40) begin abuf[na] = mem_addr; na++; end
            wd_valid = 1'b1;
            if (wd_ready && idx == sb && st < sc) begin
                wd_valid = 1'b0;
                st++;
                check("stall_mem_valid", 32'(mem_valid), 32'd0);
            end
            wd_data = wbuf[idx > 16 ? 16 : idx];
            fire = wd_ready && wd_valid;
            @(negedge clk);
            cyc++;
            if (fire) idx++;
        end
        wd_valid = 1'b0;
        if (busy) check("write_bound", 32'(busy), 32'd0);
        for (int i = 0; i <= int'(l); i++) model[8'(a + 8'(i))] = wbuf[i];
    endtask

    task automatic run_read(input logic [7:0] a, input logic [3:0] l, input int sb, input int sc,
                            output int cyc);
        int         idx = 0;
        int         st  = 0;
        logic [7:0] held;
        logic       take;
        nr = 0; na = 0; held = 8'h00;
        rd_ready = 1'b0;
        issue(1'b0, a, l);
        cyc = 0;
        while (busy && cyc < 300) begin
            if (mem_valid && na < 40) begin abuf[na] = mem_addr; na++; end
            take = 1'b0;
            rd_ready = 1'b0;
            if (rd_valid) begin
                if (idx == sb && st < sc) begin
                    if (st == 0) held = rd_data;
                    else check("bp_rd_data_hold", 32'(rd_data), 32'(held));
                    check("bp_mem_valid", 32'(mem_valid), 32'd0);
                    st++;
                end else begin
                    rd_ready = 1'b1;
                    take = 1'b1;
                end
            end
            if (take && nr < 17) begin rbuf[nr] = rd_data; rlast[nr] = rd_last; nr++; end
            @(negedge clk);
            cyc++;
            if (take) idx++;
        end
        rd_ready = 1'b0;
        if (busy) check("read_bound", 32'(busy), 32'd0);
    endtask

    task automatic verify_read(input logic [7:0] a, input logic [3:0] l);
        check("rd_count", 32'(nr), 32'(l) + 32'd1);
        for (int i = 0; i < nr && i <= int'(l); i++) begin
            check("rd_data", 32'(rbuf[i]), 32'(model[8'(a + 8'(i))]));
            check("rd_last", 32'(rlast[i]), (i == int'(l)) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic verify_addrs(input logic [7:0] a, input logic [3:0] l);
        check("addr_count", 32'(na), 32'(l) + 32'd1);
        for (int i = 0; i < na && i <= int'(l); i++)
            check("mem_addr_seq", 32'(abuf[i]), 32'(8'(a + 8'(i))));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        check({tag, "_mem_wr_rd"}, 32'(mem_wr_rd), 32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
        check({tag, "_rd_data"},   32'(rd_data),   32'd0);
        check({tag, "_rd_last"},   32'(rd_last),   32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        int cyc;
        int seen;
        res = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_len = 4'h0;
        wd_valid = 1'b0; wd_data = 8'h00; rd_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; model[i] = 8'h00; end

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_wd_ready", 32'(wd_ready), 32'd0);
        res = 1'b1;
        @(negedge clk);

        // Write then read at 0x10, four beats
        wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
        run_write(8'h10, 4'd3, -1, 0, cyc);
        check("wr4_cycles", 32'(cyc), 32'd12);
        verify_addrs(8'h10, 4'd3);
        check("wr_err", 32'(err), 32'd0);
        run_read(8'h10, 4'd3, -1, 0, cyc);
        check("rd4_cycles", 32'(cyc), 32'd16);
        verify_read(8'h10, 4'd3);
        verify_addrs(8'h10, 4'd3);

        // Address wrap
        wbuf[0] = 8'h5A; wbuf[1] = 8'h5B; wbuf[2] = 8'h5C; wbuf[3] = 8'h5D;
        run_write(8'hFE, 4'd3, -1, 0, cyc);
        verify_addrs(8'hFE, 4'd3);
        check("wrap_wr_cycles", 32'(cyc), 32'd12);
        run_read(8'hFE, 4'd3, -1, 0, cyc);
        verify_read(8'hFE, 4'd3);
        verify_addrs(8'hFE, 4'd3);
        check("wrap_mem_00", 32'(mem[0]), 32'h5C);

        // Read backpressure on beat 1 for 5 cycles
        run_read(8'h10, 4'd3, 1, 5, cyc);
        check("bp_cycles", 32'(cyc), 32'd21);
        verify_read(8'h10, 4'd3);

        // Write starvation on beat 2 for 4 cycles
        wbuf[0] = 8'h31; wbuf[1] = 8'h32; wbuf[2] = 8'h33; wbuf[3] = 8'h34;
        run_write(8'h40, 4'd3, 2, 4, cyc);
        check("starve_cycles", 32'(cyc), 32'd16);
        verify_addrs(8'h40, 4'd3);
        run_read(8'h40, 4'd3, -1, 0, cyc);
        verify_read(8'h40, 4'd3);

        // Single beat
        wbuf[0] = 8'hE7;
        run_write(8'h07, 4'd0, -1, 0, cyc);
        check("single_wr_cycles", 32'(cyc), 32'd3);
        run_read(8'h07, 4'd0, -1, 0, cyc);
        check("single_rd_cycles", 32'(cyc), 32'd4);
        verify_read(8'h07, 4'd0);

        // Maximum length: 16 beats
        for (int i = 0; i < 16; i++) wbuf[i] = 8'hC0 + 8'(i);
        run_write(8'h80, 4'hF, -1, 0, cyc);
        check("max_wr_cycles", 32'(cyc), 32'd48);
        verify_addrs(8'h80, 4'hF);
        run_read(8'h80, 4'hF, -1, 0, cyc);
        check("max_rd_cycles", 32'(cyc), 32'd64);
        verify_read(8'h80, 4'hF);

        // Asynchronous reset during RESP of beat 2
        rd_ready = 1'b1; seen = 0; cyc = 0;
        issue(1'b0, 8'h10, 4'd3);
        rd_ready = 1'b1;
        while (seen < 3 && cyc < 100) begin
            if (mem_valid) seen++;
            if (seen < 3) begin @(negedge clk); cyc++; end
        end
        check("rst_reach_beat2", 32'(seen), 32'd3);
        check("rst_pre_addr", 32'(mem_addr), 32'h12);
        res = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        rd_ready = 1'b0;
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_mem_valid", 32'(mem_valid), 32'd0);
        run_read(8'h10, 4'd3, -1, 0, cyc);
        check("post_rst_rd_cycles", 32'(cyc), 32'd16);
        verify_read(8'h10, 4'd3);

`ifdef MEM_BURST_TIMEOUT_EN
        // Memory never answers: abort after 15 RESP cycles
        mem_block = 1'b1;
        wbuf[0] = 8'h99; wbuf[1] = 8'h98; wbuf[2] = 8'h97; wbuf[3] = 8'h96;
        run_write(8'h60, 4'd3, -1, 0, cyc);
        check("to_cycles", 32'(cyc), 32'd16);
        check("to_err", 32'(err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_addr_count", 32'(na), 32'd1);
        mem_block = 1'b0;
        @(negedge clk);
        check("to_err_sticky", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) model[8'(8'h60 + 8'(i))] = mem[8'(8'h60 + 8'(i))];
        run_read(8'h10, 4'd3, -1, 0, cyc);
        check("to_err_cleared", 32'(err), 32'd0);
        verify_read(8'h10, 4'd3);
`else
        check("err_const_zero", 32'(err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
